// File: rtl/term_pkg.sv
// Shared constants, FSM state type and byte classification for the UART terminal writer.
package term_pkg;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        CLR_ROW = 2'd2,
        CLR_ALL = 2'd3
    } term_state_e;

    // True for bytes that are drawn as glyphs (space through tilde).
    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO. A push while full is ignored unless a pop happens in the same cycle.
// DEPTH must be a power of two.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk_144m,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      cnt_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign dout      = mem_q[rd_q];

    // Storage array; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk_144m) begin
        if (do_push_s) begin
            mem_q[wr_q] <= din;
        end
    end

    // Pointer and occupancy tracking; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk_144m or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push_s) wr_q <= wr_q + AW'(1);
            if (do_pop_s)  rd_q <= rd_q + AW'(1);
            case ({do_push_s, do_pop_s})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_term_writer.sv
// Turns received UART bytes into character-RAM writes with a text cursor, and echoes
// every received byte back to the transmitter through its own FIFO.
module uart_term_writer
    import term_pkg::*;
#(
    parameter int         COLS       = 50,
    parameter int         ROWS       = 15,
    parameter int         ADDR_W     = 12,
    parameter logic [7:0] ATTR       = 8'hf0,
    parameter int         IN_DEPTH   = 16,
    parameter int         ECHO_DEPTH = 16,
    parameter int         ECHO_INC   = 0
) (
    input  logic                      clk_144m,
    input  logic                      reset,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    input  logic                      tx_busy,
    output logic [7:0]                tx_data,
    output logic                      tx_ready,
    output logic                      ram_ce,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [15:0]               ram_data,
    output logic [$clog2(ROWS)-1:0]   cur_row,
    output logic [$clog2(COLS)-1:0]   cur_col,
    output logic                      overflow
);
    localparam int                CW      = $clog2(COLS);
    localparam int                RW      = $clog2(ROWS);
    localparam logic [ADDR_W-1:0] COLS_A  = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] ROW_END = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] ALL_END = ADDR_W'(COLS * ROWS - 1);

    term_state_e       state_q, state_d;
    logic [7:0]        byte_q, byte_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] clr_q, clr_d;
    logic              ram_ce_q, ram_ce_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [15:0]       ram_data_q, ram_data_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_ready_q;
    logic [1:0]        guard_q, guard_d;
    logic              overflow_q, overflow_d;
    logic              newline_s;

    logic              in_pop_s, in_full_s, in_empty_s;
    logic [7:0]        in_dout_s;
    logic              echo_pop_s, echo_full_s, echo_empty_s;
    logic [7:0]        echo_dout_s, echo_din_s;

    assign echo_din_s = rx_data + 8'(ECHO_INC);

    sync_fifo #(.WIDTH(8), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk_144m (clk_144m),
        .reset    (reset),
        .push     (rx_valid),
        .pop      (in_pop_s),
        .din      (rx_data),
        .dout     (in_dout_s),
        .full     (in_full_s),
        .empty    (in_empty_s)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(ECHO_DEPTH)) u_echo_fifo (
        .clk_144m (clk_144m),
        .reset    (reset),
        .push     (rx_valid),
        .pop      (echo_pop_s),
        .din      (echo_din_s),
        .dout     (echo_dout_s),
        .full     (echo_full_s),
        .empty    (echo_empty_s)
    );

    // Terminal FSM: pop a byte, decode it next cycle, and run row/screen clears.
    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        row_d      = row_q;
        col_d      = col_q;
        row_base_d = row_base_q;
        clr_d      = clr_q;
        ram_ce_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        in_pop_s   = 1'b0;
        newline_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!in_empty_s) begin
                    in_pop_s = 1'b1;
                    byte_d   = in_dout_s;
                    state_d  = WRITE;
                end else begin
                    state_d  = IDLE;
                end
            end
            WRITE: begin
                state_d = IDLE;
                if (is_printable(byte_q)) begin
                    ram_ce_d   = 1'b1;
                    ram_addr_d = row_base_q + ADDR_W'(col_q);
                    ram_data_d = {ATTR, byte_q};
                    if (col_q == CW'(COLS - 1)) begin
                        col_d     = '0;
                        newline_s = 1'b1;
                    end else begin
                        col_d     = col_q + CW'(1);
                    end
                end else if (byte_q == CH_CR) begin
                    col_d = '0;
                end else if (byte_q == CH_LF) begin
                    newline_s = 1'b1;
                end else if (byte_q == CH_BS) begin
                    if (col_q != '0) begin
                        col_d      = col_q - CW'(1);
                        ram_ce_d   = 1'b1;
                        ram_addr_d = row_base_q + ADDR_W'(col_q - CW'(1));
                        ram_data_d = {ATTR, CH_SPACE};
                    end else begin
                        col_d      = col_q;
                    end
                end else if (byte_q == CH_FF) begin
                    state_d = CLR_ALL;
                    clr_d   = '0;
                end else begin
                    state_d = IDLE;
                end
                // Row advance shared by LF and line wrap; the new row is then blanked.
                if (newline_s) begin
                    if (row_q == RW'(ROWS - 1)) begin
                        row_d      = '0;
                        row_base_d = '0;
                    end else begin
                        row_d      = row_q + RW'(1);
                        row_base_d = row_base_q + COLS_A;
                    end
                    clr_d   = '0;
                    state_d = CLR_ROW;
                end else begin
                    clr_d   = clr_d;
                end
            end
            CLR_ROW: begin
                ram_ce_d   = 1'b1;
                ram_addr_d = row_base_q + clr_q;
                ram_data_d = {ATTR, CH_SPACE};
                if (clr_q == ROW_END) begin
                    state_d = IDLE;
                end else begin
                    clr_d   = clr_q + ADDR_W'(1);
                end
            end
            CLR_ALL: begin
                ram_ce_d   = 1'b1;
                ram_addr_d = clr_q;
                ram_data_d = {ATTR, CH_SPACE};
                if (clr_q == ALL_END) begin
                    state_d    = IDLE;
                    row_d      = '0;
                    col_d      = '0;
                    row_base_d = '0;
                end else begin
                    clr_d      = clr_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Echo launcher: the guard counter masks uart_tx's late busy assertion after each start.
    always_comb begin
        echo_pop_s = 1'b0;
        tx_data_d  = tx_data_q;
        guard_d    = guard_q;
        if (!echo_empty_s && !tx_busy && (guard_q == 2'd0)) begin
            echo_pop_s = 1'b1;
            tx_data_d  = echo_dout_s;
            guard_d    = 2'd3;
        end else if (guard_q != 2'd0) begin
            guard_d    = guard_q - 2'd1;
        end else begin
            guard_d    = guard_q;
        end
    end

    // Sticky drop flag: a push into a full FIFO that is not popped in the same cycle.
    always_comb begin
        overflow_d = overflow_q;
        if (rx_valid && ((in_full_s && !in_pop_s) || (echo_full_s && !echo_pop_s))) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_144m or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            byte_q     <= 8'h00;
            row_q      <= '0;
            col_q      <= '0;
            row_base_q <= '0;
            clr_q      <= '0;
            ram_ce_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= 16'h0000;
            tx_data_q  <= 8'h00;
            tx_ready_q <= 1'b0;
            guard_q    <= 2'd0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            row_q      <= row_d;
            col_q      <= col_d;
            row_base_q <= row_base_d;
            clr_q      <= clr_d;
            ram_ce_q   <= ram_ce_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            tx_data_q  <= tx_data_d;
            tx_ready_q <= echo_pop_s;
            guard_q    <= guard_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_ready = tx_ready_q;
    assign ram_ce   = ram_ce_q;
    assign ram_addr = ram_addr_q;
    assign ram_data = ram_data_q;
    assign cur_row  = row_q;
    assign cur_col  = col_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_term_writer.sv
// Directed scoreboard bench for uart_term_writer: expected RAM writes and echo bytes are
// queued when stimulus is driven and checked as the DUT produces them.
module tb_uart_term_writer;
    localparam int         COLS     = 50;
    localparam int         ROWS     = 15;
    localparam int         ADDR_W   = 12;
    localparam logic [7:0] ATTR     = 8'hf0;
    localparam int         ECHO_INC = 1;

    logic              clk_144m;
    logic              reset;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              tx_busy;
    logic [7:0]        tx_data;
    logic              tx_ready;
    logic              ram_ce;
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0]       ram_data;
    logic [3:0]        cur_row;
    logic [5:0]        cur_col;
    logic              overflow;

    int compared   = 0;
    int mismatched = 0;

    logic [27:0] exp_ram [$];
    logic [7:0]  exp_tx  [$];

    int m_row = 0;
    int m_col = 0;
    int m_rb  = 0;

    uart_term_writer #(
        .COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .ATTR(ATTR),
        .IN_DEPTH(16), .ECHO_DEPTH(16), .ECHO_INC(ECHO_INC)
    ) dut (
        .clk_144m (clk_144m),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_busy  (tx_busy),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .ram_ce   (ram_ce),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .cur_row  (cur_row),
        .cur_col  (cur_col),
        .overflow (overflow)
    );

    initial clk_144m = 1'b0;
    always #5 clk_144m = ~clk_144m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic exp_write(input int addr, input logic [7:0] ch);
        exp_ram.push_back({ADDR_W'(addr), ATTR, ch});
    endtask

    task automatic model_newline();
        if (m_row == ROWS - 1) begin
            m_row = 0;
            m_rb  = 0;
        end else begin
            m_row = m_row + 1;
            m_rb  = m_rb + COLS;
        end
        for (int i = 0; i < COLS; i++) exp_write(m_rb + i, 8'h20);
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7e) begin
            exp_write(m_rb + m_col, b);
            if (m_col == COLS - 1) begin
                m_col = 0;
                model_newline();
            end else begin
                m_col = m_col + 1;
            end
        end else if (b == 8'h0d) begin
            m_col = 0;
        end else if (b == 8'h0a) begin
            model_newline();
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col = m_col - 1;
                exp_write(m_rb + m_col, 8'h20);
            end
        end else if (b == 8'h0c) begin
            for (int i = 0; i < COLS * ROWS; i++) exp_write(i, 8'h20);
            m_row = 0;
            m_col = 0;
            m_rb  = 0;
        end
    endtask

    // Drive one byte; called and returns 1 time unit after a rising edge.
    task automatic send(input logic [7:0] b, input int gap, input bit kept, input bit echoed);
        if (kept)   model_byte(b);
        if (echoed) exp_tx.push_back(b + 8'(ECHO_INC));
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk_144m); #1;
        rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk_144m); #1;
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_ram.size() != 0 || exp_tx.size() != 0) && n < 4000) begin
            @(posedge clk_144m); #1;
            n++;
        end
        repeat (10) begin
            @(posedge clk_144m); #1;
        end
        chk({tag, "_ram_left"}, 32'(exp_ram.size()), 32'd0);
        chk({tag, "_tx_left"}, 32'(exp_tx.size()), 32'd0);
    endtask

    // RAM write scoreboard.
    always @(negedge clk_144m) begin
        if (reset && ram_ce) begin
            compared++;
            assert (exp_ram.size() != 0) else begin
                mismatched++;
                $error("FAIL ram_unexpected: observed write %0h=%0h expected none", ram_addr, ram_data);
            end
            if (exp_ram.size() != 0) chk("ram_write", 32'({ram_addr, ram_data}), 32'(exp_ram.pop_front()));
        end
    end

    // Echo scoreboard.
    always @(negedge clk_144m) begin
        if (reset && tx_ready) begin
            compared++;
            assert (exp_tx.size() != 0) else begin
                mismatched++;
                $error("FAIL tx_unexpected: observed %0h expected none", tx_data);
            end
            if (exp_tx.size() != 0) chk("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
        end
    end

    initial begin
        reset    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_busy  = 1'b0;
        repeat (3) @(posedge clk_144m);
        #1;
        chk("rst_ram_ce", 32'(ram_ce), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_data", 32'(ram_data), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_row", 32'(cur_row), 32'd0);
        chk("rst_col", 32'(cur_col), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b1;
        @(posedge clk_144m); #1;

        // 1: "AB", with the 3-cycle rx_valid -> ram_ce latency checked on 'A'
        send(8'h41, 0, 1'b1, 1'b1);
        chk("lat_cyc1", 32'(ram_ce), 32'd0);
        @(posedge clk_144m); #1;
        chk("lat_cyc2", 32'(ram_ce), 32'd0);
        @(posedge clk_144m); #1;
        chk("lat_cyc3", 32'(ram_ce), 32'd1);
        send(8'h42, 4, 1'b1, 1'b1);
        drain("t1");
        chk("t1_col", 32'(cur_col), 32'd2);

        // 2: CR, 50 x 'x' (wrap into row 1 with row clear), then 'y'
        send(8'h0d, 4, 1'b1, 1'b1);
        for (int i = 0; i < COLS; i++) send(8'h78, 4, 1'b1, 1'b1);
        send(8'h79, 4, 1'b1, 1'b1);
        drain("t2");
        chk("t2_row", 32'(cur_row), 32'd1);
        chk("t2_col", 32'(cur_col), 32'd1);

        // 3: LF down to row 14, then LF wraps to row 0 and clears addrs 0..49
        for (int i = 0; i < 13; i++) send(8'h0a, 4, 1'b1, 1'b1);
        drain("t3a");
        chk("t3_row14", 32'(cur_row), 32'd14);
        send(8'h0a, 4, 1'b1, 1'b1);
        drain("t3b");
        chk("t3_row0", 32'(cur_row), 32'd0);
        chk("t3_col", 32'(cur_col), 32'd1);

        // 4: CR, 'Q', BS, BS -> second BS at column 0 writes nothing
        send(8'h0d, 4, 1'b1, 1'b1);
        send(8'h51, 4, 1'b1, 1'b1);
        send(8'h08, 4, 1'b1, 1'b1);
        send(8'h08, 4, 1'b1, 1'b1);
        drain("t4");
        chk("t4_col", 32'(cur_col), 32'd0);
        chk("t4_overflow", 32'(overflow), 32'd0);

        // 5: FF then 20 bytes back-to-back with tx stalled: input keeps 16, echo keeps FF + 15
        tx_busy = 1'b1;
        send(8'h0c, 0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) send(8'h61 + 8'(i), 0, i < 16, i < 15);
        chk("t5_overflow", 32'(overflow), 32'd1);
        tx_busy = 1'b0;
        drain("t5");
        chk("t5_row", 32'(cur_row), 32'd0);
        chk("t5_col", 32'(cur_col), 32'd16);

        // 6: reset in the middle of a screen clear
        send(8'h0c, 0, 1'b1, 1'b1);
        repeat (100) begin
            @(posedge clk_144m); #1;
        end
        chk("t6_clearing", 32'(ram_ce), 32'd1);
        chk("t6_col_pre", 32'(cur_col), 32'd16);
        reset = 1'b0;
        #1;
        chk("t6_ram_ce", 32'(ram_ce), 32'd0);
        chk("t6_row", 32'(cur_row), 32'd0);
        chk("t6_col", 32'(cur_col), 32'd0);
        chk("t6_overflow", 32'(overflow), 32'd0);
        exp_ram.delete();
        exp_tx.delete();
        m_row = 0;
        m_col = 0;
        m_rb  = 0;
        repeat (2) @(posedge clk_144m);
        #1;
        reset = 1'b1;
        @(posedge clk_144m); #1;
        send(8'h5a, 4, 1'b1, 1'b1);
        drain("t6");
        chk("t6_col_after", 32'(cur_col), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
